branch_predictor: RTL and testbench

Parametrised next-PC predictor for the fetch stage of the RISC-V core. It generalises fixed JAL-only redirection into a direct-mapped branch target buffer (BTB) with saturating direction counters and a return-address stack (RAS). Fetch gets a combinational same-cycle prediction for `lookup_pc`. Execute writes one resolved control-flow outcome per cycle back through the update port.

---
 rtl/branch_pkg.sv | 20 ++
 rtl/return_address_stack.sv | 63 ++++++
 rtl/branch_predictor.sv | 139 +++++++++++++
 tb/tb_branch_predictor.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared definitions for the fetch-stage next-PC predictor: control-flow kind
// encodings and direction-counter constants derived from the counter width.
package branch_pkg;

    localparam logic [1:0] KIND_BRANCH = 2'b00;
    localparam logic [1:0] KIND_JAL    = 2'b01;
    localparam logic [1:0] KIND_RET    = 2'b10;
    localparam logic [1:0] KIND_CALL   = 2'b11;

    // Weakly not-taken: MSB clear, all lower bits set.
    function automatic int unsigned ctr_reset_value(input int unsigned ctr_bits);
        return (32'd1 << (ctr_bits - 1)) - 32'd1;
    endfunction

    // Weakly taken: MSB set, all lower bits clear.
    function automatic int unsigned ctr_alloc_value(input int unsigned ctr_bits);
        return 32'd1 << (ctr_bits - 1);
    endfunction

endpackage

// File: rtl/return_address_stack.sv
// Circular return-address stack; pushing when full overwrites the oldest entry,
// popping when empty does nothing, flush empties it and wins over push/pop.
module return_address_stack
    import branch_pkg::*;
#(
    parameter int RAS_DEPTH = 4,
    parameter int XLEN      = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  logic [XLEN-1:0]              push_data,
    output logic [XLEN-1:0]              top,
    output logic [$clog2(RAS_DEPTH):0]   count
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam logic [PW:0] FULL = (PW + 1)'(RAS_DEPTH);

    logic [XLEN-1:0] mem_q [RAS_DEPTH];
    logic [XLEN-1:0] mem_d [RAS_DEPTH];
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW:0]     count_q, count_d;

    // ptr_q always points at the next free slot, so the top lives one below it.
    always_comb begin
        mem_d   = mem_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (push) begin
            mem_d[ptr_q] = push_data;
            ptr_d        = ptr_q + PW'(1);
            if (count_q != FULL) begin
                count_d = count_q + (PW + 1)'(1);
            end
        end else if (pop && (count_q != '0)) begin
            ptr_d   = ptr_q - PW'(1);
            count_d = count_q - (PW + 1)'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            ptr_q   <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end

    assign top   = mem_q[ptr_q - PW'(1)];
    assign count = count_q;

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with saturating direction counters plus a return-address
// stack; gives a same-cycle next-PC prediction and accepts one update per cycle.
module branch_predictor
    import branch_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BTB_ENTRIES = 16,
    parameter int RAS_DEPTH   = 4,
    parameter int CTR_BITS    = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [XLEN-1:0]              lookup_pc,
    output logic                         pred_hit,
    output logic                         pred_taken,
    output logic [XLEN-1:0]              pred_target,
    input  logic                         upd_valid,
    input  logic [XLEN-1:0]              upd_pc,
    input  logic [1:0]                   upd_kind,
    input  logic                         upd_taken,
    input  logic [XLEN-1:0]              upd_target,
    input  logic                         flush,
    output logic [$clog2(RAS_DEPTH):0]   ras_count
);

    localparam int IDX  = $clog2(BTB_ENTRIES);
    localparam int TAGW = XLEN - IDX - 2;
    localparam logic [CTR_BITS-1:0] CTR_RESET = CTR_BITS'(ctr_reset_value(CTR_BITS));
    localparam logic [CTR_BITS-1:0] CTR_ALLOC = CTR_BITS'(ctr_alloc_value(CTR_BITS));

    logic                valid_q  [BTB_ENTRIES];
    logic                valid_d  [BTB_ENTRIES];
    logic [TAGW-1:0]     tag_q    [BTB_ENTRIES];
    logic [TAGW-1:0]     tag_d    [BTB_ENTRIES];
    logic [XLEN-1:0]     target_q [BTB_ENTRIES];
    logic [XLEN-1:0]     target_d [BTB_ENTRIES];
    logic [1:0]          kind_q   [BTB_ENTRIES];
    logic [1:0]          kind_d   [BTB_ENTRIES];
    logic [CTR_BITS-1:0] ctr_q    [BTB_ENTRIES];
    logic [CTR_BITS-1:0] ctr_d    [BTB_ENTRIES];

    logic [IDX-1:0]  lk_idx, up_idx;
    logic [TAGW-1:0] lk_tag, up_tag;
    logic            up_hit;
    logic [XLEN-1:0] ras_top;
    logic            ras_push, ras_pop;
    logic            unused_low_bits;

    assign lk_idx = lookup_pc[IDX+1:2];
    assign lk_tag = lookup_pc[XLEN-1:IDX+2];
    assign up_idx = upd_pc[IDX+1:2];
    assign up_tag = upd_pc[XLEN-1:IDX+2];
    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    assign unused_low_bits = ^{lookup_pc[1:0], upd_pc[1:0]};

    always_comb begin
        pred_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        pred_taken  = pred_hit &&
                      ((kind_q[lk_idx] != KIND_BRANCH) || ctr_q[lk_idx][CTR_BITS-1]);
        pred_target = lookup_pc + XLEN'(4);
        if (pred_taken) begin
            // An empty stack leaves the BTB's last-seen return target as the best guess.
            if ((kind_q[lk_idx] == KIND_RET) && (ras_count != '0)) begin
                pred_target = ras_top;
            end else begin
                pred_target = target_q[lk_idx];
            end
        end
    end

    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        kind_d   = kind_q;
        ctr_d    = ctr_q;
        if (upd_valid) begin
            if (upd_kind == KIND_BRANCH) begin
                if (up_hit) begin
                    target_d[up_idx] = upd_target;
                    kind_d[up_idx]   = KIND_BRANCH;
                    if (upd_taken) begin
                        if (ctr_q[up_idx] != '1) ctr_d[up_idx] = ctr_q[up_idx] + CTR_BITS'(1);
                    end else begin
                        if (ctr_q[up_idx] != '0) ctr_d[up_idx] = ctr_q[up_idx] - CTR_BITS'(1);
                    end
                end else if (upd_taken) begin
                    valid_d[up_idx]  = 1'b1;
                    tag_d[up_idx]    = up_tag;
                    target_d[up_idx] = upd_target;
                    kind_d[up_idx]   = KIND_BRANCH;
                    ctr_d[up_idx]    = CTR_ALLOC;
                end
            end else begin
                valid_d[up_idx]  = 1'b1;
                tag_d[up_idx]    = up_tag;
                target_d[up_idx] = upd_target;
                kind_d[up_idx]   = upd_kind;
                ctr_d[up_idx]    = '1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                kind_q[i]   <= KIND_BRANCH;
                ctr_q[i]    <= CTR_RESET;
            end
        end else begin
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            target_q <= target_d;
            kind_q   <= kind_d;
            ctr_q    <= ctr_d;
        end
    end

    assign ras_push = upd_valid && (upd_kind == KIND_CALL);
    assign ras_pop  = upd_valid && (upd_kind == KIND_RET);

    return_address_stack #(
        .RAS_DEPTH (RAS_DEPTH),
        .XLEN      (XLEN)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (ras_push),
        .pop       (ras_pop),
        .flush     (flush),
        .push_data (upd_pc + XLEN'(4)),
        .top       (ras_top),
        .count     (ras_count)
    );

endmodule

// File: tb/tb_branch_predictor.sv
// Directed-vector bench for branch_predictor with hand-computed expectations
// for BTB allocation, counter saturation, RAS wrap/underflow, flush and reset.
module tb_branch_predictor;

    import branch_pkg::*;

    logic        clk;
    logic        reset;
    logic [31:0] lookup_pc;
    logic        pred_hit;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [1:0]  upd_kind;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        flush;
    logic [2:0]  ras_count;

    int vectors;
    int miscompares;

    branch_predictor #(
        .XLEN        (32),
        .BTB_ENTRIES (16),
        .RAS_DEPTH   (4),
        .CTR_BITS    (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .lookup_pc   (lookup_pc),
        .pred_hit    (pred_hit),
        .pred_taken  (pred_taken),
        .pred_target (pred_target),
        .upd_valid   (upd_valid),
        .upd_pc      (upd_pc),
        .upd_kind    (upd_kind),
        .upd_taken   (upd_taken),
        .upd_target  (upd_target),
        .flush       (flush),
        .ras_count   (ras_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] pc,
                               input logic exp_hit, input logic exp_taken,
                               input logic [31:0] exp_target);
        lookup_pc = pc;
        #1;
        chk({tag, "_hit"},    {31'd0, pred_hit},   {31'd0, exp_hit});
        chk({tag, "_taken"},  {31'd0, pred_taken}, {31'd0, exp_taken});
        chk({tag, "_target"}, pred_target,         exp_target);
    endtask

    task automatic checkCount(input string tag, input logic [2:0] exp_count);
        #1;
        chk(tag, {29'd0, ras_count}, {29'd0, exp_count});
    endtask

    task automatic applyStimulus(input logic [31:0] pc, input logic [1:0] kind,
                                 input logic taken, input logic [31:0] target,
                                 input logic fl);
        upd_valid  = 1'b1;
        upd_pc     = pc;
        upd_kind   = kind;
        upd_taken  = taken;
        upd_target = target;
        flush      = fl;
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        flush     = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        lookup_pc   = 32'd0;
        upd_valid   = 1'b0;
        upd_pc      = 32'd0;
        upd_kind    = KIND_BRANCH;
        upd_taken   = 1'b0;
        upd_target  = 32'd0;
        flush       = 1'b0;

        #11;
        checkOutput("reset_lookup8", 32'd8, 1'b0, 1'b0, 32'd12);
        checkCount("reset_count", 3'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // JAL at 4: invisible in the cycle it is written, visible the next.
        upd_valid  = 1'b1;
        upd_pc     = 32'd4;
        upd_kind   = KIND_JAL;
        upd_taken  = 1'b0;
        upd_target = 32'd16;
        checkOutput("jal_same_cycle", 32'd4, 1'b0, 1'b0, 32'd8);
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        checkOutput("jal_next_cycle", 32'd4, 1'b1, 1'b1, 32'd16);

        applyStimulus(32'd20, KIND_BRANCH, 1'b0, 32'd8, 1'b0);
        checkOutput("br_nt_miss", 32'd20, 1'b0, 1'b0, 32'd24);
        applyStimulus(32'd20, KIND_BRANCH, 1'b1, 32'd8, 1'b0);
        checkOutput("br_alloc", 32'd20, 1'b1, 1'b1, 32'd8);
        applyStimulus(32'd20, KIND_BRANCH, 1'b0, 32'd8, 1'b0);
        applyStimulus(32'd20, KIND_BRANCH, 1'b0, 32'd8, 1'b0);
        checkOutput("br_two_nt", 32'd20, 1'b1, 1'b0, 32'd24);
        // Counter sits at 0: one more not-taken then one taken must leave it at 1.
        applyStimulus(32'd20, KIND_BRANCH, 1'b0, 32'd8, 1'b0);
        applyStimulus(32'd20, KIND_BRANCH, 1'b1, 32'd8, 1'b0);
        checkOutput("br_saturate_low", 32'd20, 1'b1, 1'b0, 32'd24);
        applyStimulus(32'd20, KIND_BRANCH, 1'b1, 32'd8, 1'b0);
        checkOutput("br_retaken", 32'd20, 1'b1, 1'b1, 32'd8);

        applyStimulus(32'h40, KIND_CALL, 1'b0, 32'h100, 1'b0);
        checkCount("call_count", 3'd1);
        applyStimulus(32'h104, KIND_RET, 1'b0, 32'h44, 1'b0);
        checkCount("ret_count", 3'd0);
        applyStimulus(32'h40, KIND_CALL, 1'b0, 32'h100, 1'b0);
        checkCount("call2_count", 3'd1);
        checkOutput("call_lookup", 32'h40, 1'b1, 1'b1, 32'h100);
        checkOutput("ret_lookup", 32'h104, 1'b1, 1'b1, 32'h44);
        applyStimulus(32'h104, KIND_RET, 1'b0, 32'h44, 1'b0);
        checkCount("ret2_count", 3'd0);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(32'h200 + 32'(i) * 32'h10, KIND_CALL, 1'b0, 32'h400, 1'b0);
        end
        checkCount("ras_full_count", 3'd4);
        checkOutput("ras_full_top", 32'h104, 1'b1, 1'b1, 32'h244);
        applyStimulus(32'h104, KIND_RET, 1'b0, 32'h44, 1'b0);
        checkCount("pop1_count", 3'd3);
        checkOutput("pop1_top", 32'h104, 1'b1, 1'b1, 32'h234);
        applyStimulus(32'h104, KIND_RET, 1'b0, 32'h44, 1'b0);
        checkOutput("pop2_top", 32'h104, 1'b1, 1'b1, 32'h224);
        applyStimulus(32'h104, KIND_RET, 1'b0, 32'h44, 1'b0);
        checkOutput("pop3_top", 32'h104, 1'b1, 1'b1, 32'h214);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(32'h104, KIND_RET, 1'b0, 32'h44, 1'b0);
        end
        checkCount("underflow_count", 3'd0);
        checkOutput("empty_ret_lookup", 32'h104, 1'b1, 1'b1, 32'h44);
        applyStimulus(32'h300, KIND_CALL, 1'b0, 32'h400, 1'b0);
        checkCount("push_after_empty", 3'd1);
        checkOutput("push_after_empty_top", 32'h104, 1'b1, 1'b1, 32'h304);

        applyStimulus(32'h310, KIND_CALL, 1'b0, 32'h500, 1'b1);
        checkCount("flush_push_count", 3'd0);
        checkOutput("flush_btb_update", 32'h310, 1'b1, 1'b1, 32'h500);

        // Reset dropped between edges must clear state without waiting for a clock.
        lookup_pc = 32'h310;
        #1;
        reset = 1'b0;
        #1;
        chk("async_reset_hit", {31'd0, pred_hit}, 32'd0);
        chk("async_reset_count", {29'd0, ras_count}, 32'd0);
        chk("async_reset_target", pred_target, 32'h314);
        #3;
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("wrap_target", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0000_0000);
        checkOutput("post_reset_jal_gone", 32'd4, 1'b0, 1'b0, 32'd8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
